model_scalar_integer_multiplier: RTL and testbench

// - Iterative unsigned integer multiplier; the inverse of the scalar integer divider.
// - Computes DATA_A_IN * DATA_B_IN with one shift-add step per cycle.
// - Same START/READY handshake as the divider, so the arithmetic layer can use it

---
 rtl/model_arithmetic_pkg.sv | 13 +
 rtl/model_scalar_integer_multiplier.sv | 79 +++++++
 tb/tb_model_scalar_integer_multiplier.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/model_arithmetic_pkg.sv
// Shared definitions for the scalar arithmetic units (multiplier and divider).
// Both units step through the same three-state START/READY sequence.
package model_arithmetic_pkg;

    localparam logic ZERO_DATA = 1'b0;

    typedef enum logic [1:0] {
        STARTER_STATE  = 2'd0,
        MULTIPLY_STATE = 2'd1,
        ENDER_STATE    = 2'd2
    } arithmetic_state_t;

endpackage : model_arithmetic_pkg

// File: rtl/model_scalar_integer_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// fixed DATA_SIZE-iteration latency, START/READY handshake shared with the divider.
module model_scalar_integer_multiplier
    import model_arithmetic_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 OVERFLOW_OUT
);

    // The counter must reach DATA_SIZE even if CONTROL_SIZE was set too small.
    localparam int COUNT_BITS = (CONTROL_SIZE > $clog2(DATA_SIZE + 1)) ?
                                CONTROL_SIZE : $clog2(DATA_SIZE + 1);
    localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(DATA_SIZE - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

    arithmetic_state_t        state_reg;
    logic [2*DATA_SIZE-1:0]   multiplicand_reg;
    logic [DATA_SIZE-1:0]     multiplier_reg;
    logic [2*DATA_SIZE-1:0]   product_reg;
    logic [COUNT_BITS-1:0]    count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= STARTER_STATE;
            multiplicand_reg <= '0;
            multiplier_reg   <= '0;
            product_reg      <= '0;
            count_reg        <= '0;
            DATA_OUT         <= {DATA_SIZE{ZERO_DATA}};
            OVERFLOW_OUT     <= 1'b0;
            READY            <= 1'b0;
        end else begin
            case (state_reg)
                STARTER_STATE: begin
                    READY <= 1'b0;
                    if (START) begin
                        multiplicand_reg <= {{DATA_SIZE{ZERO_DATA}}, DATA_A_IN};
                        multiplier_reg   <= DATA_B_IN;
                        product_reg      <= '0;
                        count_reg        <= '0;
                        state_reg        <= MULTIPLY_STATE;
                    end
                end
                MULTIPLY_STATE: begin
                    if (multiplier_reg[0]) begin
                        product_reg <= product_reg + multiplicand_reg;
                    end
                    multiplicand_reg <= multiplicand_reg << 1;
                    multiplier_reg   <= multiplier_reg >> 1;
                    count_reg        <= count_reg + COUNT_ONE;
                    // No early exit on zero operands: latency stays constant.
                    if (count_reg == LAST_COUNT) begin
                        state_reg <= ENDER_STATE;
                    end
                end
                ENDER_STATE: begin
                    DATA_OUT     <= product_reg[DATA_SIZE-1:0];
                    OVERFLOW_OUT <= |product_reg[2*DATA_SIZE-1:DATA_SIZE];
                    READY        <= 1'b1;
                    state_reg    <= STARTER_STATE;
                end
                default: begin
                    READY     <= 1'b0;
                    state_reg <= STARTER_STATE;
                end
            endcase
        end
    end

endmodule : model_scalar_integer_multiplier

// File: tb/tb_model_scalar_integer_multiplier.sv
// Scoreboard bench for the iterative multiplier: stimulus pushes expected results,
// a negedge monitor pops one entry per READY pulse and checks value and latency.
module tb_model_scalar_integer_multiplier;

    localparam int DATA_SIZE = 64;
    localparam int LATENCY   = DATA_SIZE + 2;  // issue negedge -> READY-visible negedge
    localparam int N_RANDOM  = 1000;

    typedef struct {
        logic [DATA_SIZE-1:0] data;
        logic                 ovf;
        int                   ready_cycle;
        string                name;
    } exp_t;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 START;
    logic                 READY;
    logic [DATA_SIZE-1:0] DATA_A_IN;
    logic [DATA_SIZE-1:0] DATA_B_IN;
    logic [DATA_SIZE-1:0] DATA_OUT;
    logic                 OVERFLOW_OUT;

    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    exp_t sb_q[$];

    model_scalar_integer_multiplier #(
        .DATA_SIZE   (DATA_SIZE),
        .CONTROL_SIZE(4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .READY       (READY),
        .DATA_A_IN   (DATA_A_IN),
        .DATA_B_IN   (DATA_B_IN),
        .DATA_OUT    (DATA_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

    task automatic check64(input string name, input logic [DATA_SIZE-1:0] act,
                           input logic [DATA_SIZE-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
        end
    endtask

    // Monitor: every READY pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST === 1'b0 && READY === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got READY=1 at cycle %0d expected no result",
                         cycle_cnt);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check64({e.name, "_data"}, DATA_OUT, e.data);
                check64({e.name, "_ovf"}, {63'd0, OVERFLOW_OUT}, {63'd0, e.ovf});
                check64({e.name, "_latency"}, 64'(cycle_cnt), 64'(e.ready_cycle));
                $display("txn %s: A*B -> data=0x%h ovf=%0b at cycle %0d",
                         e.name, DATA_OUT, OVERFLOW_OUT, cycle_cnt);
            end
        end
    end

    task automatic push_exp(input string name, input logic [DATA_SIZE-1:0] a,
                            input logic [DATA_SIZE-1:0] b);
        logic [2*DATA_SIZE-1:0] p;
        exp_t e;
        p = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
        e.data        = p[DATA_SIZE-1:0];
        e.ovf         = |p[2*DATA_SIZE-1:DATA_SIZE];
        e.ready_cycle = cycle_cnt + LATENCY;
        e.name        = name;
        sb_q.push_back(e);
    endtask

    // Called on a negedge: present operands, pulse START for one cycle.
    task automatic issue_pulse(input string name, input logic [DATA_SIZE-1:0] a,
                               input logic [DATA_SIZE-1:0] b);
        DATA_A_IN = a;
        DATA_B_IN = b;
        START     = 1'b1;
        push_exp(name, a, b);
        @(negedge CLK);
        START     = 1'b0;
        DATA_A_IN = '0;
        DATA_B_IN = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_ready(input string name, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (n < budget) begin
            @(negedge CLK);
            n++;
            if (READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got no READY expected one within %0d cycles",
                     name, budget);
        end
    endtask

    initial begin
        bit ok;
        logic [DATA_SIZE-1:0] ra, rb;

        RST = 1'b1; START = 1'b0; DATA_A_IN = '0; DATA_B_IN = '0;
        repeat (3) @(negedge CLK);
        check64("reset_data", DATA_OUT, 64'd0);
        check64("reset_ovf", {63'd0, OVERFLOW_OUT}, 64'd0);
        check64("reset_ready", {63'd0, READY}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Directed vectors with hand-computed products.
        issue_pulse("3x5", 64'd3, 64'd5);
        wait_drain("3x5", 100);
        repeat (5) @(negedge CLK);
        check64("hold_data", DATA_OUT, 64'd15);
        check64("hold_ready_low", {63'd0, READY}, 64'd0);

        issue_pulse("max_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_drain("max_x2", 100);
        issue_pulse("2p32_sq", 64'h1_0000_0000, 64'h1_0000_0000);
        wait_drain("2p32_sq", 100);
        issue_pulse("zero_x_dead", 64'd0, 64'hDEAD);
        wait_drain("zero_x_dead", 100);

        // Second START while busy must be ignored: exactly one result (42).
        issue_pulse("7x6", 64'd7, 64'd6);
        repeat (10) @(negedge CLK);
        DATA_A_IN = 64'd1; DATA_B_IN = 64'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_drain("7x6", 100);
        repeat (LATENCY + 5) @(negedge CLK);

        // Reset 10 cycles into a multiply aborts it without a READY.
        DATA_A_IN = 64'd9; DATA_B_IN = 64'd9; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check64("abort_data", DATA_OUT, 64'd0);
        check64("abort_ovf", {63'd0, OVERFLOW_OUT}, 64'd0);
        repeat (LATENCY + 5) @(negedge CLK);
        issue_pulse("4x4", 64'd4, 64'd4);
        wait_drain("4x4", 100);

        // START held high: a new operand pair is accepted on every READY cycle.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        DATA_A_IN = ra; DATA_B_IN = rb; START = 1'b1;
        push_exp("rnd", ra, rb);
        for (int i = 1; i < N_RANDOM; i++) begin
            wait_ready("rnd", LATENCY + 4, ok);
            if (!ok) break;
            ra = (i % 4 == 0) ? 64'($urandom) : {$urandom, $urandom};
            rb = (i % 3 == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            DATA_A_IN = ra; DATA_B_IN = rb;
            push_exp("rnd", ra, rb);
        end
        wait_ready("rnd_last", LATENCY + 4, ok);
        START = 1'b0;
        wait_drain("rnd", 200);
        repeat (LATENCY + 5) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_model_scalar_integer_multiplier
